// File: rtl/int_fp_pkg.sv
// Shared definitions for the INT/FP16 adder wrapper: mode encodings, FP16 exponent
// field location and the {mode, tag, data} entry layout.
package int_fp_pkg;

  localparam logic MODE_INT = 1'b0;
  localparam logic MODE_FP  = 1'b1;

  localparam int DATA_W       = 16;
  localparam int FP16_EXP_MSB = 14;
  localparam int FP16_EXP_LSB = 10;
  localparam logic [4:0] FP16_EXP_MAX = 5'h1F;

  // Reference layout for the default tag width; the wrapper packs its FIFO words in the same order.
  localparam int ENTRY_TAG_W = 4;
  typedef struct packed {
    logic                   mode;
    logic [ENTRY_TAG_W-1:0] tag;
    logic [DATA_W-1:0]      data;
  } entry_t;

  // FP16 inf/NaN: all-ones exponent. Never flagged for integer results.
  function automatic logic fp16_exc(input logic mode, input logic [DATA_W-1:0] data);
    return (mode == MODE_FP) && (data[FP16_EXP_MSB:FP16_EXP_LSB] == FP16_EXP_MAX);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, natural-wrap pointers and an occupancy count.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/int_fp_add_issue.sv
// Issue/collect wrapper around the dual-mode INT/FP16 adder, with credit-based issue so no result
// is ever dropped. Optional `INT_FP_ISSUE_EXC_EN adds a per-result FP16 inf/NaN flag (out_exc).
module int_fp_add_issue
  import int_fp_pkg::*;
#(
  parameter int LAT    = 0,
  parameter int IDEPTH = 4,
  parameter int RDEPTH = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             add_mode,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_c,
  output logic             out_mode,
  output logic [TAG_W-1:0] out_tag
`ifdef INT_FP_ISSUE_EXC_EN
  ,
  output logic             out_exc
`endif
);

  // Both streams: a transfer happens on a cycle where valid && ready; the producer holds its
  // payload stable while valid && !ready, and valid never depends on ready.

  localparam int OP_W = 2 * DATA_W + TAG_W + 1;
`ifdef INT_FP_ISSUE_EXC_EN
  localparam int RES_W = DATA_W + TAG_W + 2;
`else
  localparam int RES_W = DATA_W + TAG_W + 1;
`endif
  localparam int IAW = $clog2(IDEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam logic [IAW:0] IDEPTH_CNT = IDEPTH[IAW:0];
  localparam logic [RAW:0] CREDIT_MAX = RDEPTH[RAW:0];

  logic [OP_W-1:0]  op_wdata, op_rdata;
  logic             op_push, op_full, op_empty;
  logic [IAW:0]     op_count;
  logic [RES_W-1:0] res_wdata, res_rdata;
  logic             res_full, res_empty, out_pop;
  logic [RAW:0]     res_count;

  logic             issue, issue_mode;
  logic [TAG_W-1:0] issue_tag;
  logic             wr_valid, wr_mode;
  logic [TAG_W-1:0] wr_tag;
  logic [RAW:0]     credit_q, credit_d;

  assign in_ready = (op_count != IDEPTH_CNT);
  assign op_push  = in_valid && in_ready;
  assign op_wdata = {in_mode, in_tag, in_a, in_b};

  sync_fifo #(.WIDTH(OP_W), .DEPTH(IDEPTH)) u_op_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (op_push),
    .wdata (op_wdata),
    .pop   (issue),
    .rdata (op_rdata),
    .full  (op_full),
    .empty (op_empty),
    .count (op_count)
  );

  // A credit stands for one free result-FIFO slot not yet claimed by an issued operation.
  assign issue      = !op_empty && (credit_q != '0);
  assign issue_mode = op_rdata[OP_W-1];
  assign issue_tag  = op_rdata[2*DATA_W +: TAG_W];
  assign add_mode   = issue ? issue_mode : MODE_INT;
  assign add_a      = issue ? op_rdata[DATA_W +: DATA_W] : '0;
  assign add_b      = issue ? op_rdata[0 +: DATA_W] : '0;

  generate
    if (LAT == 0) begin : g_comb
      assign wr_valid = issue;
      assign wr_mode  = issue_mode;
      assign wr_tag   = issue_tag;
    end else begin : g_pipe
      logic [LAT-1:0]   pv_q, pv_d;
      logic [LAT-1:0]   pm_q, pm_d;
      logic [TAG_W-1:0] pt_q [LAT];
      logic [TAG_W-1:0] pt_d [LAT];

      always_comb begin
        pv_d    = pv_q;
        pm_d    = pm_q;
        pt_d    = pt_q;
        pv_d[0] = issue;
        pm_d[0] = issue_mode;
        pt_d[0] = issue_tag;
        for (int i = 1; i < LAT; i++) begin
          pv_d[i] = pv_q[i-1];
          pm_d[i] = pm_q[i-1];
          pt_d[i] = pt_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv_q <= '0;
          pm_q <= '0;
          for (int i = 0; i < LAT; i++) pt_q[i] <= '0;
        end else begin
          pv_q <= pv_d;
          pm_q <= pm_d;
          pt_q <= pt_d;
        end
      end

      assign wr_valid = pv_q[LAT-1];
      assign wr_mode  = pm_q[LAT-1];
      assign wr_tag   = pt_q[LAT-1];
    end
  endgenerate

`ifdef INT_FP_ISSUE_EXC_EN
  assign res_wdata = {fp16_exc(wr_mode, add_c), wr_mode, wr_tag, add_c};
`else
  assign res_wdata = {wr_mode, wr_tag, add_c};
`endif

  sync_fifo #(.WIDTH(RES_W), .DEPTH(RDEPTH)) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_valid),
    .wdata (res_wdata),
    .pop   (out_pop),
    .rdata (res_rdata),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  assign out_valid = !res_empty;
  assign out_pop   = out_valid && out_ready;
  assign out_c     = res_rdata[0 +: DATA_W];
  assign out_tag   = res_rdata[DATA_W +: TAG_W];
  assign out_mode  = res_rdata[DATA_W + TAG_W];
`ifdef INT_FP_ISSUE_EXC_EN
  assign out_exc   = res_rdata[DATA_W + TAG_W + 1];
`endif

  always_comb begin
    case ({issue, out_pop})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   credit_d = credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credit_q <= CREDIT_MAX;
    else        credit_q <= credit_d;
  end

  // Credits plus stored results never exceed the FIFO size, so a result write always finds room.
  a_credit_range: assert property (@(posedge clk) disable iff (!rst_n)
    credit_q <= CREDIT_MAX);
  a_credit_slots: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, credit_q} + {1'b0, res_count}) <= {1'b0, CREDIT_MAX});
  a_no_res_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_valid && res_full));
  a_no_op_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(op_push && op_full));

endmodule

// File: doc/int_fp_add_issue.md
Name: int_fp_add_issue

Overview:
Initiator/consumer wrapper for the dual-mode INT/FP16 adder (mode 0 = packed integer add, mode 1 = FP16 add).
- Accepts operand pairs on a valid/ready stream and buffers them.
- Issues pairs to the adder's a/b/mode interface and captures c after a fixed adder latency.
- Returns results in order, with tag and mode, on a valid/ready stream.
- Credit-based issue guarantees that no result is ever dropped under output backpressure.

Parameters:
- LAT, 0, adder latency in cycles (0 = combinational adder, 1 = pipelined adder build).
- IDEPTH, 4, operand FIFO depth (power of 2, ≥2).
- RDEPTH, 4, result FIFO depth (power of 2, ≥2); also the credit count.
- TAG_W, 4, width of the user tag.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand FIFO not full
- in_mode  in  1  0 = INT, 1 = FP16
- in_a  in  16  operand a
- in_b  in  16  operand b
- in_tag  in  TAG_W  user tag
- add_mode  out  1  to adder mode
- add_a  out  16  to adder a
- add_b  out  16  to adder b
- add_c  in  16  from adder c
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_c  out  16  result
- out_mode  out  1  mode of result
- out_tag  out  TAG_W  tag of result

Behaviour:
- Reset is decided: rst_n asynchronous, active-low; clock clk.
- Reset state: both FIFOs empty, credit = RDEPTH, latency pipe cleared.
  - out_valid = 0, out_c/out_mode/out_tag = 0.
  - in_ready = 1 (FIFO empty); in_valid is ignored while rst_n is low.
- Input acceptance:
  - Push when in_valid && in_ready.
  - in_ready = (icount != IDEPTH), with no same-cycle bypass when the FIFO is full.
- Issue condition: issue = operand FIFO non-empty && credit != 0. At most one issue per cycle.
- Adder drive:
  - When issuing: add_a/add_b/add_mode are driven combinationally from the FIFO head.
  - When not issuing: add_a = add_b = 16'h0000 and add_mode = 0.
- Latency pipe: a LAT-deep shift register of {valid, mode, tag}.
  - An issued entry enters at the issue cycle.
  - At stage LAT, add_c is written with mode/tag into the result FIFO.
  - For LAT = 0, the write happens in the issue cycle.
- Credit counter:
  - Decrements on issue and increments on output pop.
  - Simultaneous issue + pop: unchanged.
  - The credit never goes below 0 or above RDEPTH (assertion).
  - Consequence: the result FIFO can never overflow.
- Output stream:
  - out_valid = result FIFO non-empty; out_* come from the FIFO head.
  - Pop when out_valid && out_ready.
  - Data is stable while out_valid && !out_ready.
- Ordering: strict FIFO; results leave in issue order.
- Simultaneous push + pop on either FIFO, when not full/empty respectively, leaves its count unchanged.
- Pointers are log2(depth) bits and wrap naturally; the count is log2(depth)+1 bits.
- Reset mid-operation: all in-flight and buffered entries are discarded and no output is produced for them. Entries the adder pipeline finishes after reset release are ignored, because the pipe valid bits are cleared.
- Throughput: 1 result/cycle sustained when out_ready = 1.
- Latency: in_valid → out_valid = LAT+2 cycles (FIFO write, issue, result write registered).

Optional Feature:
INT_FP_ISSUE_EXC_EN
- Defined:
  - Adds output out_exc (1 bit), stored per result-FIFO entry.
  - out_exc = out_mode && (out_c[14:10] == 5'h1F), flagging FP16 inf/NaN results; it is always 0 in INT mode.
  - Reset value 0.
- Undefined: the port and the storage are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package int_fp_pkg:
  - MODE_INT/MODE_FP constants.
  - FP16_EXP_MSB/LSB = 14/10.
  - FP16_EXP_MAX = 5'h1F.
  - Entry typedef {mode, tag, data}.
- One sub-module, sync_fifo (params WIDTH, DEPTH): push/pop/full/empty/count. It is instantiated twice, for operands and results.

Test Plan:
- INT mode, LAT = 0: push a=16'h0003, b=16'h0005, tag=1 → out_c=16'h0008, out_tag=1, out_mode=0, 2 cycles after the push.
- FP16 mode: 3C00+3C00 → 4000; 4000+3C00 → 4200. Repeat with LAT = 1: same values, out_valid delayed one extra cycle.
- Backpressure, out_ready = 0, push 8 pairs tags 0..7:
  - exactly 4 issues occur (credit → 0) and 4 remain queued;
  - in_ready drops after the 8th push;
  - then out_ready = 1 → tags 0..7 emerge in order, one per cycle after the first.
- Simultaneous push/pop at full result FIFO, with out_ready toggling 1/0 per cycle over 20 random INT pairs: every result matches the scoreboard, with no loss or duplication.
- Reset asserted with 3 entries buffered and 1 in flight: out_valid = 0 immediately; after release, no stale results, credit = RDEPTH, in_ready = 1.
- INT_FP_ISSUE_EXC_EN: stub adder returns 16'h7C00 in FP mode → out_exc = 1; same value in INT mode → out_exc = 0.
